// File: rtl/regfile_pkg.sv
// Shared defaults, FSM encoding and init pattern for the register-file write controller.
// Optional feature macro: REGFILE_WR_ELIDE_EN (see regfile_init_writer).
package regfile_pkg;

    localparam int DEF_DATA_W   = 2;
    localparam int DEF_DEPTH    = 3;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_ERRCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [DEF_DATA_W-1:0] init_pattern(
        input logic [DEF_ADDR_W-1:0] addr
    );
        return DEF_DATA_W'(addr);
    endfunction

endpackage

// File: rtl/regfile_shadow.sv
// Shadow copy of the register file contents: one write port, one async read port.
// Only instantiated when REGFILE_WR_ELIDE_EN is defined.
module regfile_shadow
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Mirror every write issued to the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++)
                if (waddr == ADDR_W'(i)) mem[i] <= wdata;
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++)
            if (raddr == ADDR_W'(i)) rdata = mem[i];
    end

endmodule

// File: rtl/regfile_init_writer.sv
// Write-side controller: init sweep data[i]=i, then forwards checked write requests.
// Macro REGFILE_WR_ELIDE_EN: skip writes whose data already matches a shadow copy.
module regfile_init_writer
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ERRCNT_W = DEF_ERRCNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                init_done,
    output logic                busy,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep;
    logic              accept;
    logic              in_range;
    logic              elide;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;
    logic              done_set;
    logic              err_d;

    assign req_ready = (state == RUN) & ~start;
    assign accept    = req_valid & req_ready;
    assign in_range  = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
    assign busy      = (state == INIT);

`ifdef REGFILE_WR_ELIDE_EN
    logic [DATA_W-1:0] shadow_rd;

    regfile_shadow #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en_d),
        .waddr (wr_addr_d),
        .wdata (wr_data_d),
        .raddr (req_addr),
        .rdata (shadow_rd)
    );

    assign elide = (req_data == shadow_rd);
`else
    assign elide = 1'b0;
`endif

    // State and sweep pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    // Next state and next write: the start edge itself issues address 0.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        sweep      = 1'b0;
        sweep_addr = '0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        done_set   = 1'b0;
        err_d      = 1'b0;
        case (state)
            IDLE: sweep = start;
            INIT: begin
                sweep      = 1'b1;
                sweep_addr = ptr;
            end
            RUN: begin
                sweep = start;
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (!elide) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = req_addr;
                        wr_data_d = req_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (sweep) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sweep_addr;
            wr_data_d = DATA_W'(init_pattern(DEF_ADDR_W'(sweep_addr)));
            if (sweep_addr == ADDR_W'(DEPTH - 1)) begin
                state_d  = RUN;
                ptr_d    = '0;
                done_set = 1'b1;
            end else begin
                state_d  = INIT;
                ptr_d    = sweep_addr + ADDR_W'(1);
            end
        end
    end

    // Registered write port, status flags and saturating error counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
            init_done <= init_done | done_set;
            err       <= err_d;
            if (err_d && (err_cnt != '1))
                err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_init_writer.sv
// Self-checking bench for regfile_init_writer: directed cases plus random traffic
// against a behavioural model of the write stream, flags and error counter.
module tb_regfile_init_writer;

    localparam int DATA_W   = 2;
    localparam int DEPTH    = 3;
    localparam int ADDR_W   = 2;
    localparam int ERRCNT_W = 8;
    localparam int CNT_MAX  = 255;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                init_done;
    logic                busy;
    logic                err;
    logic [ERRCNT_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    regfile_init_writer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .init_done (init_done),
        .busy      (busy),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: sweep as "writes remaining", file contents as an array.
    int         m_left = 0;
    bit         m_done = 1'b0;
    bit         m_wr_en = 1'b0;
    logic [1:0] m_addr = '0;
    logic [1:0] m_data = '0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;
    logic [1:0] m_mem [DEPTH];
    bit         m_ready;

    assign m_ready = m_done && (m_left == 0) && !start;

    always @(posedge clk or posedge reset) begin
        int idx;
        if (reset) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_wr_en <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else begin
            m_wr_en <= 1'b0;
            m_err   <= 1'b0;
            idx = -1;
            if (m_left > 0) idx = DEPTH - m_left;
            else if (start) idx = 0;
            if (idx >= 0) begin
                m_wr_en     <= 1'b1;
                m_addr      <= 2'(idx);
                m_data      <= 2'(idx);
                m_mem[idx]  <= 2'(idx);
                m_left      <= DEPTH - 1 - idx;
                if (idx == DEPTH - 1) m_done <= 1'b1;
            end else if (m_ready && req_valid) begin
                if (int'(req_addr) >= DEPTH) begin
                    m_err <= 1'b1;
                    m_cnt <= (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
                end
`ifdef REGFILE_WR_ELIDE_EN
                else if (m_mem[req_addr] == req_data) begin
                end
`endif
                else begin
                    m_wr_en          <= 1'b1;
                    m_addr           <= req_addr;
                    m_data           <= req_data;
                    m_mem[req_addr]  <= req_data;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_wr_en", 32'(wr_en), 32'(m_wr_en));
            chk("m_wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("m_wr_data", 32'(wr_data), 32'(m_data));
            chk("m_init_done", 32'(init_done), 32'(m_done));
            chk("m_busy", 32'(busy), 32'(m_left > 0));
            chk("m_err", 32'(err), 32'(m_err));
            chk("m_err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("m_req_ready", 32'(req_ready), 32'(m_ready));
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_data = '0;

        step();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_ready", 32'(req_ready), 0);
        step();
        reset = 1'b0;

        // Initial sweep.
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("sw0_en", 32'(wr_en), 1);
        chk("sw0_addr", 32'(wr_addr), 0);
        chk("sw0_busy", 32'(busy), 1);
        step();
        @(negedge clk);
        chk("sw1_addr", 32'(wr_addr), 1);
        chk("sw1_data", 32'(wr_data), 1);
        step();
        @(negedge clk);
        chk("sw2_addr", 32'(wr_addr), 2);
        chk("sw2_data", 32'(wr_data), 2);
        chk("sw2_done", 32'(init_done), 1);
        chk("sw2_busy", 32'(busy), 0);
        step();
        @(negedge clk);
        chk("idle_wr_en", 32'(wr_en), 0);
        chk("idle_ready", 32'(req_ready), 1);

        // In-range request.
        step();
        req_valid = 1'b1;
        req_addr = 2'd1;
        req_data = 2'd3;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("req_en", 32'(wr_en), 1);
        chk("req_addr", 32'(wr_addr), 1);
        chk("req_data", 32'(wr_data), 3);
        chk("req_err", 32'(err), 0);

        // Out-of-range request, then saturation.
        step();
        req_valid = 1'b1;
        req_addr = 2'd3;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("oor_en", 32'(wr_en), 0);
        chk("oor_err", 32'(err), 1);
        chk("oor_cnt", 32'(err_cnt), 1);
        step();
        req_valid = 1'b1;
        repeat (299) step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("sat_cnt", 32'(err_cnt), 255);

        // Start collides with a request: sweep first, request after.
        step();
        start = 1'b1;
        req_valid = 1'b1;
        req_addr = 2'd0;
        req_data = 2'd2;
        @(negedge clk);
        chk("coll_ready", 32'(req_ready), 0);
        step();
        start = 1'b0;
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) break;
            step();
            n++;
        end
        chk("coll_wait", 32'(n), 3);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("coll_en", 32'(wr_en), 1);
        chk("coll_data", 32'(wr_data), 2);

        // Reset after the second sweep write.
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        chk("mid_addr", 32'(wr_addr), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_en", 32'(wr_en), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        chk("mid_rst_done", 32'(init_done), 0);
        chk("mid_rst_addr", 32'(wr_addr), 0);
        step();
        reset = 1'b0;
        req_valid = 1'b1;
        req_addr = 2'd0;
        req_data = 2'd1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_en", 32'(wr_en), 0);
            step();
        end
        req_valid = 1'b0;

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step();
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 15) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_addr = 2'($urandom_range(0, 3));
            req_data = 2'($urandom_range(0, 3));
        end

        // Write elision after a fresh sweep.
        step();
        reset = 1'b1;
        start = 1'b0;
        req_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        req_valid = 1'b1;
        req_addr = 2'd2;
        req_data = 2'd2;
        @(negedge clk);
        chk("el_ready", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        @(negedge clk);
`ifdef REGFILE_WR_ELIDE_EN
        chk("el_same_en", 32'(wr_en), 0);
`else
        chk("el_same_en", 32'(wr_en), 1);
`endif
        step();
        req_valid = 1'b1;
        req_data = 2'd1;
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("el_diff_en", 32'(wr_en), 1);
        chk("el_diff_data", 32'(wr_data), 1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
